// File: rtl/universal_reg_sync_pkg.sv
// Shared operating-mode encodings for the universal register and its bench.
package universal_reg_defs;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_e;

endpackage

// File: rtl/universal_reg_sync_next_state.sv
// Combinational next-state and carry selection for the universal register.
module ureg_next_state
   import universal_reg_defs::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] Q,
   input  logic             Carry,
   input  logic [2:0]       Mode,
   input  logic [WIDTH-1:0] D,
   input  logic             SerialIn,
   output logic [WIDTH-1:0] next_q,
   output logic             next_carry
);

   always_comb begin
      next_q     = Q;
      next_carry = Carry;
      case (mode_e'(Mode))
         MODE_HOLD: begin
            next_q     = Q;
            next_carry = Carry;
         end
         MODE_LOAD: begin
            next_q     = D;
            next_carry = 1'b0;
         end
         MODE_SHL: begin
            next_q     = {Q[WIDTH-2:0], SerialIn};
            next_carry = Q[WIDTH-1];
         end
         MODE_SHR: begin
            next_q     = {SerialIn, Q[WIDTH-1:1]};
            next_carry = Q[0];
         end
         MODE_ROL: begin
            next_q     = {Q[WIDTH-2:0], Q[WIDTH-1]};
            next_carry = Q[WIDTH-1];
         end
         MODE_ROR: begin
            next_q     = {Q[0], Q[WIDTH-1:1]};
            next_carry = Q[0];
         end
         // Carry is the top bit of the WIDTH+1 sum, so all-ones wraps with Carry=1.
         MODE_INC: {next_carry, next_q} = {1'b0, Q} + {{WIDTH{1'b0}}, 1'b1};
         MODE_DEC: begin
            next_q     = Q - {{(WIDTH-1){1'b0}}, 1'b1};
            next_carry = (Q == '0);
         end
      endcase
   end

endmodule

// File: rtl/universal_reg_sync.sv
// WIDTH-bit register with sync reset, enable, and hold/load/shift/rotate/count modes.
module universal_reg_sync
   import universal_reg_defs::*;
#(
   parameter int unsigned      WIDTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [2:0]       Mode,
   input  logic [WIDTH-1:0] D,
   input  logic             SerialIn,
   output logic [WIDTH-1:0] Q,
   output logic             Carry,
   output logic             Zero
);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("universal_reg_sync: WIDTH must be at least 2");
      end
   endgenerate

   logic [WIDTH-1:0] next_q;
   logic             next_carry;

   ureg_next_state #(.WIDTH(WIDTH)) u_next (
      .Q          (Q),
      .Carry      (Carry),
      .Mode       (Mode),
      .D          (D),
      .SerialIn   (SerialIn),
      .next_q     (next_q),
      .next_carry (next_carry)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Q     <= RESET_VALUE;
         Carry <= 1'b0;
      end else if (Enable) begin
         Q     <= next_q;
         Carry <= next_carry;
      end
   end

   assign Zero = (Q == '0);

endmodule
